// File: rtl/serial_to_parallel_aligner.sv
// Serial-to-parallel byte aligner: hunts for COMMA in the bit stream, confirms LOCK_COUNT aligned
// commas, then emits every following byte. Optional macro COMMA_STRIP_EN suppresses VALID_OUT on commas.

module serial_to_parallel_aligner #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SERIAL_IN,
    output logic [7:0] DATA_OUT,
    output logic       VALID_OUT,
    output logic       ACTIVE
);

    typedef enum logic [1:0] {StSearch, StSync, StActive} state_e;

    localparam logic [3:0] LockTarget = 4'(LOCK_COUNT);

    state_e     state_q, state_d;
    // Only the seven most recent bits are stored; SERIAL_IN supplies the eighth.
    logic [6:0] shreg_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] comma_cnt_q, comma_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       active_q;

    logic [7:0] word;
    logic       is_comma;
    logic       boundary;

    assign word     = {shreg_q, SERIAL_IN};
    assign is_comma = (word == COMMA);
    assign boundary = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        unique case (state_q)
            StSearch: begin
                if (is_comma) begin
                    bit_cnt_d   = 3'd0;
                    comma_cnt_d = 4'd1;
                    state_d     = (LOCK_COUNT == 1) ? StActive : StSync;
                end
            end
            StSync: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_cnt_q + 4'd1;
                        if (comma_cnt_d == LockTarget) begin
                            state_d = StActive;
                        end
                    end else begin
                        // Misaligned run: drop it and hunt again from the next edge.
                        state_d     = StSearch;
                        comma_cnt_d = 4'd0;
                        bit_cnt_d   = 3'd0;
                    end
                end
            end
            StActive: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    data_d = word;
`ifdef COMMA_STRIP_EN
                    valid_d = ~is_comma;
`else
                    valid_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = StSearch;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= StSearch;
            shreg_q     <= 7'd0;
            bit_cnt_q   <= 3'd0;
            comma_cnt_q <= 4'd0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= word[6:0];
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            active_q    <= (state_d == StActive);
        end
    end

    assign DATA_OUT  = data_q;
    assign VALID_OUT = valid_q;
    assign ACTIVE    = active_q;

endmodule

// File: tb/tb_serial_to_parallel_aligner.sv
// Directed bench for serial_to_parallel_aligner: byte-vector table plus hand-written reset,
// offset and lock-count-1 sequences; one instance per LOCK_COUNT setting.

module tb_serial_to_parallel_aligner;

`ifdef COMMA_STRIP_EN
    localparam logic CommaValid = 1'b0;
`else
    localparam logic CommaValid = 1'b1;
`endif

    typedef struct {
        logic [7:0] din;
        logic [7:0] data;
        logic       valid;
        logic       active;
    } vec_t;

    logic       CLK;
    logic       RESET;
    logic       sin;
    logic [7:0] d0, d1;
    logic       v0, v1, a0, a1;
    logic       sel;
    int         tests;
    int         fails;
    vec_t       tbl [29];

    serial_to_parallel_aligner #(.COMMA(8'hBC), .LOCK_COUNT(4)) u_dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .SERIAL_IN(sin),
        .DATA_OUT (d0),
        .VALID_OUT(v0),
        .ACTIVE   (a0)
    );

    serial_to_parallel_aligner #(.COMMA(8'hBC), .LOCK_COUNT(1)) u_dut1 (
        .CLK      (CLK),
        .RESET    (RESET),
        .SERIAL_IN(sin),
        .DATA_OUT (d1),
        .VALID_OUT(v1),
        .ACTIVE   (a1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply(input int lo, input int hi);
        int pulses;
        for (int i = lo; i <= hi; i++) begin
            pulses = 0;
            for (int k = 7; k >= 0; k--) begin
                send_bit(tbl[i].din[k]);
                pulses += int'(sel ? v1 : v0);
            end
            check($sformatf("vec%0d data", i), sel ? d1 : d0, tbl[i].data);
            check($sformatf("vec%0d valid", i), {7'd0, sel ? v1 : v0}, {7'd0, tbl[i].valid});
            check($sformatf("vec%0d active", i), {7'd0, sel ? a1 : a0}, {7'd0, tbl[i].active});
            check($sformatf("vec%0d pulses", i), 8'(pulses), {7'd0, tbl[i].valid});
        end
    endtask

    task automatic do_reset();
        sin   = 1'b0;
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset data", sel ? d1 : d0, 8'h00);
        check("reset valid", {7'd0, sel ? v1 : v0}, 8'h00);
        check("reset active", {7'd0, sel ? a1 : a0}, 8'h00);
        RESET = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        sel   = 1'b0;
        sin   = 1'b0;
        RESET = 1'b0;

        // Four commas lock, then data; comma inside the payload.
        tbl[0]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{8'hBC, 8'h00, 1'b0, 1'b1};
        tbl[4]  = '{8'h25, 8'h25, 1'b1, 1'b1};
        tbl[5]  = '{8'hBC, 8'hBC, CommaValid, 1'b1};
        tbl[6]  = '{8'h3C, 8'h3C, 1'b1, 1'b1};
        tbl[7]  = '{8'h5A, 8'h5A, 1'b1, 1'b1};
        // Bit-offset stream after three junk bits.
        tbl[8]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{8'hBC, 8'h00, 1'b0, 1'b1};
        tbl[12] = '{8'hF9, 8'hF9, 1'b1, 1'b1};
        tbl[13] = '{8'h4F, 8'h4F, 1'b1, 1'b1};
        // Broken comma run falls back to search.
        tbl[14] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        tbl[15] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        tbl[16] = '{8'h26, 8'h00, 1'b0, 1'b0};
        tbl[17] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        tbl[18] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        tbl[19] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        tbl[20] = '{8'hBC, 8'h00, 1'b0, 1'b1};
        tbl[21] = '{8'h39, 8'h39, 1'b1, 1'b1};
        // Relock after a mid-byte reset.
        tbl[22] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        tbl[23] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        tbl[24] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        tbl[25] = '{8'hBC, 8'h00, 1'b0, 1'b1};
        tbl[26] = '{8'hA5, 8'hA5, 1'b1, 1'b1};
        // LOCK_COUNT = 1 instance.
        tbl[27] = '{8'hBC, 8'h00, 1'b0, 1'b1};
        tbl[28] = '{8'hA8, 8'hA8, 1'b1, 1'b1};

        do_reset();
        apply(0, 7);

        // Reset partway through a byte while locked: outputs clear before the next edge.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        RESET = 1'b0;
        #1;
        check("async rst data", d0, 8'h00);
        check("async rst valid", {7'd0, v0}, 8'h00);
        check("async rst active", {7'd0, a0}, 8'h00);
        sin = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        apply(22, 26);

        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("junk active", {7'd0, a0}, 8'h00);
        check("junk valid", {7'd0, v0}, 8'h00);
        apply(8, 13);

        do_reset();
        apply(14, 21);

        sel = 1'b1;
        do_reset();
        apply(27, 28);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
